// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: direction codes, controller state
// encoding and the index width used by both the fill and traceback counters.
package nw_pkg;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;
    localparam logic [1:0] DIR_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } tb_state_e;

    localparam int NW_N = 128;

    // One spare bit so an index can hold N itself without wrapping.
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int IDX_W = idx_w(NW_N);

endpackage

// File: rtl/tb_move_decoder.sv
// Maps the current cell and the returned direction code to the move taken.
// Edge cells force the only legal move; a reserved code degrades to DIAG.
module tb_move_decoder
    import nw_pkg::*;
#(
    parameter int IW = IDX_W
) (
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    input  logic [1:0]    rd_data,
    output logic [1:0]    move,
    output logic          err_hit
);

    always_comb begin
        move    = rd_data;
        err_hit = 1'b0;
        if (i == '0) begin
            move = DIR_LEFT;
        end else if (j == '0) begin
            move = DIR_UP;
        end else if (rd_data == DIR_RSVD) begin
            move    = DIR_DIAG;
            err_hit = 1'b1;
        end
    end

endmodule

// File: rtl/traceback_read_counter.sv
// Walks the stored direction matrix from (N-1,N-1) back to (0,0), reading
// one direction code per step and handing each move to the alignment builder.
//
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_ISSUE  | latch read address, strobe rd_en next cycle
//   ST_WAIT   | count down the direction-RAM read latency
//   ST_DECIDE | rd_data valid; register move and raise step_valid
//   ST_EMIT   | hold the step until accepted, then move (i,j)
//   ST_DONE   | (0,0) reached; one-cycle end_traceback pulse
module traceback_read_counter
    import nw_pkg::*;
#(
    parameter  int N      = 128,
    parameter  int RD_LAT = 1,
    localparam int AW     = $clog2(N*N),
    localparam int IW     = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          step_valid,
    input  logic          step_ready,
    output logic [1:0]    step_move,
    output logic          busy,
    output logic          end_traceback,
    output logic          err
);

    tb_state_e     state, state_nxt;
    logic [1:0]    lat_cnt;
    logic [1:0]    dec_move;
    logic          dec_err;
    logic [IW-1:0] i_nxt, j_nxt;
    logic          last_step;

    tb_move_decoder #(.IW(IW)) u_dec (
        .i       (i),
        .j       (j),
        .rd_data (rd_data),
        .move    (dec_move),
        .err_hit (dec_err)
    );

    // Only meaningful in EMIT, where the boundary forcing keeps these from wrapping.
    assign i_nxt     = (step_move != DIR_LEFT) ? i - IW'(1) : i;
    assign j_nxt     = (step_move != DIR_UP)   ? j - IW'(1) : j;
    assign last_step = (i_nxt == '0) && (j_nxt == '0);
    assign rd_addr   = AW'(32'(i) * 32'(N) + 32'(j));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy          = (state != ST_IDLE);
        end_traceback = (state == ST_DONE);
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_WAIT;
            ST_WAIT:   if (lat_cnt == 2'd0) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = ST_EMIT;
            ST_EMIT:   if (step_ready) state_nxt = last_step ? ST_DONE : ST_ISSUE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i          <= IW'(N-1);
            j          <= IW'(N-1);
            rd_en      <= 1'b0;
            lat_cnt    <= 2'd0;
            step_valid <= 1'b0;
            step_move  <= DIR_DIAG;
            err        <= 1'b0;
        end else begin
            rd_en <= (state == ST_ISSUE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i   <= IW'(N-1);
                        j   <= IW'(N-1);
                        err <= 1'b0;
                    end
                end
                ST_ISSUE: lat_cnt <= 2'(RD_LAT-1);
                ST_WAIT: begin
                    if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
                end
                ST_DECIDE: begin
                    step_move  <= dec_move;
                    step_valid <= 1'b1;
                    if (dec_err) err <= 1'b1;
                end
                ST_EMIT: begin
                    if (step_ready) begin
                        i          <= i_nxt;
                        j          <= j_nxt;
                        step_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
